// File: rtl/alu_issue_stage_if.sv
// rtl/alu_issue_stage_if.sv - handshake and data bundle between decode, issue stage and ALU
// slave is the issue stage's view; master is the driver/consumer side.
interface alu_issue_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        f7b5;
  logic [4:0]  rd;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] a_out;
  logic [31:0] b_out;
  logic [3:0]  alu_ctrl;
  logic        br_inv;
  logic        is_branch;
  logic [4:0]  rd_out;
  logic        illegal;

  modport slave (
    input  in_valid, opcode, funct3, f7b5, rd, rs1_data, rs2_data, imm, out_ready,
    output in_ready, out_valid, a_out, b_out, alu_ctrl, br_inv, is_branch, rd_out, illegal
  );

  modport master (
    output in_valid, opcode, funct3, f7b5, rd, rs1_data, rs2_data, imm, out_ready,
    input  in_ready, out_valid, a_out, b_out, alu_ctrl, br_inv, is_branch, rd_out, illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - ALU issue stage: RISC-V field decode into a 2-entry elastic buffer
// Only decoded fields are stored; outputs come straight from the head entry registers.
module alu_issue_stage (
  input  logic              clk,
  input  logic              rst_n,
  alu_issue_stage_if.slave  bus
);
  localparam int DEPTH = 2;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_EQ  = 4'b1111;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic        br_inv;
    logic        is_branch;
    logic [4:0]  rd;
    logic        illegal;
  } entry_t;

  entry_t      w_dec;
  entry_t      w_head;
  logic        w_legal;
  logic [3:0]  w_ctrl;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic        w_br;
  logic        w_inv;
  logic        w_push;
  logic        w_pop;
  logic [1:0]  w_next_count;

  entry_t      r_mem [DEPTH];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;
  logic        r_in_ready;

  always_comb begin
    w_legal = 1'b1;
    w_ctrl  = CTRL_ADD;
    w_a     = bus.rs1_data;
    w_b     = bus.rs2_data;
    w_br    = 1'b0;
    w_inv   = 1'b0;
    case (bus.opcode)
      OP_R: begin
        case (bus.funct3)
          3'b000:  w_ctrl = bus.f7b5 ? CTRL_SUB : CTRL_ADD;
          3'b010:  w_ctrl = CTRL_SLT;
          3'b110:  w_ctrl = CTRL_OR;
          3'b111:  w_ctrl = CTRL_AND;
          default: w_legal = 1'b0;
        endcase
      end
      OP_I: begin
        w_b = bus.imm;
        case (bus.funct3)
          3'b000:  w_ctrl = CTRL_ADD;
          3'b010:  w_ctrl = CTRL_SLT;
          3'b110:  w_ctrl = CTRL_OR;
          3'b111:  w_ctrl = CTRL_AND;
          default: w_legal = 1'b0;
        endcase
      end
      OP_LOAD, OP_STORE: w_b = bus.imm;
      OP_LUI: begin
        w_a = '0;
        w_b = bus.imm;
      end
      OP_BRANCH: begin
        w_br = 1'b1;
        case (bus.funct3)
          3'b000:  w_ctrl = CTRL_EQ;
          3'b001: begin w_ctrl = CTRL_EQ;  w_inv = 1'b1; end
          3'b100:  w_ctrl = CTRL_SLT;
          3'b101: begin w_ctrl = CTRL_SLT; w_inv = 1'b1; end
          default: w_legal = 1'b0;
        endcase
      end
      default: w_legal = 1'b0;
    endcase

    // Illegal entries carry a benign ADD of zeros so a careless consumer does no harm.
    w_dec.rd = bus.rd;
    if (w_legal) begin
      w_dec.a         = w_a;
      w_dec.b         = w_b;
      w_dec.ctrl      = w_ctrl;
      w_dec.br_inv    = w_inv;
      w_dec.is_branch = w_br;
      w_dec.illegal   = 1'b0;
    end else begin
      w_dec.a         = '0;
      w_dec.b         = '0;
      w_dec.ctrl      = CTRL_ADD;
      w_dec.br_inv    = 1'b0;
      w_dec.is_branch = 1'b0;
      w_dec.illegal   = 1'b1;
    end
  end

  assign w_push       = bus.in_valid & r_in_ready;
  assign w_pop        = (r_count != 2'd0) & bus.out_ready;
  assign w_next_count = r_count + {1'b0, w_push} - {1'b0, w_pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
      r_in_ready <= 1'b1;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_dec;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count    <= w_next_count;
      r_in_ready <= (w_next_count != 2'd2);
    end
  end

  assign w_head        = r_mem[r_rd_ptr];
  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = (r_count != 2'd0);
  assign bus.a_out     = w_head.a;
  assign bus.b_out     = w_head.b;
  assign bus.alu_ctrl  = w_head.ctrl;
  assign bus.br_inv    = w_head.br_inv;
  assign bus.is_branch = w_head.is_branch;
  assign bus.rd_out    = w_head.rd;
  assign bus.illegal   = w_head.illegal;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed bench for alu_issue_stage with a queue-based reference model
// Inputs change on the falling edge; outputs are checked on the falling edge and 1ns after it.
module tb_alu_issue_stage;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  alu_issue_stage_if bus ();

  alu_issue_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic        br_inv;
    logic        is_branch;
    logic [4:0]  rd;
    logic        illegal;
  } exp_t;

  exp_t q[$];

  // Reference: mnemonic-level meaning of each encoding.
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                 input logic [4:0] rd, input logic [31:0] rs1,
                                 input logic [31:0] rs2, input logic [31:0] imm);
    exp_t  e;
    string mn;
    mn = "bad";
    if (op == 7'h33 && f3 == 0) mn = f7 ? "sub" : "add";
    if (op == 7'h33 && f3 == 2) mn = "slt";
    if (op == 7'h33 && f3 == 6) mn = "or";
    if (op == 7'h33 && f3 == 7) mn = "and";
    if (op == 7'h13 && f3 == 0) mn = "addi";
    if (op == 7'h13 && f3 == 2) mn = "slti";
    if (op == 7'h13 && f3 == 6) mn = "ori";
    if (op == 7'h13 && f3 == 7) mn = "andi";
    if (op == 7'h03 || op == 7'h23) mn = "mem";
    if (op == 7'h37) mn = "lui";
    if (op == 7'h63 && f3 == 0) mn = "beq";
    if (op == 7'h63 && f3 == 1) mn = "bne";
    if (op == 7'h63 && f3 == 4) mn = "blt";
    if (op == 7'h63 && f3 == 5) mn = "bge";
    e = '{a: rs1, b: rs2, ctrl: 4'd2, br_inv: 0, is_branch: 0, rd: rd, illegal: 0};
    if (mn == "bad") begin
      e.a = 0; e.b = 0; e.illegal = 1;
    end
    if (mn == "sub") e.ctrl = 4'd6;
    if (mn == "slt" || mn == "slti" || mn == "blt" || mn == "bge") e.ctrl = 4'd7;
    if (mn == "or" || mn == "ori") e.ctrl = 4'd1;
    if (mn == "and" || mn == "andi") e.ctrl = 4'd0;
    if (mn == "beq" || mn == "bne") e.ctrl = 4'd15;
    if (mn == "addi" || mn == "slti" || mn == "ori" || mn == "andi" || mn == "mem") e.b = imm;
    if (mn == "lui") begin e.a = 0; e.b = imm; end
    if (mn == "beq" || mn == "bne" || mn == "blt" || mn == "bge") e.is_branch = 1;
    if (mn == "bne" || mn == "bge") e.br_inv = 1;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model state advances on the same edges as the DUT, using only the spec's handshake rules.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      automatic bit pop  = bus.out_ready && q.size() != 0;
      automatic bit push = bus.in_valid && q.size() != 2;
      automatic exp_t e = model(bus.opcode, bus.funct3, bus.f7b5, bus.rd,
                                bus.rs1_data, bus.rs2_data, bus.imm);
      if (pop) void'(q.pop_front());
      if (push) q.push_back(e);
    end
  end

  always @(negedge clk) begin
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, q.size() != 0});
    chk("in_ready", {31'd0, bus.in_ready}, {31'd0, q.size() != 2});
    if (q.size() != 0) begin
      chk("a_out", bus.a_out, q[0].a);
      chk("b_out", bus.b_out, q[0].b);
      chk("alu_ctrl", {28'd0, bus.alu_ctrl}, {28'd0, q[0].ctrl});
      chk("br_inv", {31'd0, bus.br_inv}, {31'd0, q[0].br_inv});
      chk("is_branch", {31'd0, bus.is_branch}, {31'd0, q[0].is_branch});
      chk("rd_out", {27'd0, bus.rd_out}, {27'd0, q[0].rd});
      chk("illegal", {31'd0, bus.illegal}, {31'd0, q[0].illegal});
    end
  end

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic [4:0] rd, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] imm);
    @(negedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.funct3   = f3;
    bus.f7b5     = f7;
    bus.rd       = rd;
    bus.rs1_data = rs1;
    bus.rs2_data = rs2;
    bus.imm      = imm;
  endtask

  task automatic idle();
    @(negedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.in_valid = 0; bus.opcode = 0; bus.funct3 = 0; bus.f7b5 = 0; bus.rd = 0;
    bus.rs1_data = 0; bus.rs2_data = 0; bus.imm = 0; bus.out_ready = 1'b1;
    #12;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_a_out", bus.a_out, 32'd0);
    chk("rst_alu_ctrl", {28'd0, bus.alu_ctrl}, 32'd0);
    rst_n = 1'b1;

    // ADD then SUB, each visible one edge after acceptance.
    drive(7'h33, 3'b000, 1'b0, 5'd4, 32'd5, 32'd7, 32'd99);
    drive(7'h33, 3'b000, 1'b1, 5'd5, 32'd5, 32'd7, 32'd99);
    chk("lit_add_ctrl", {28'd0, bus.alu_ctrl}, 32'h2);
    chk("lit_add_a", bus.a_out, 32'd5);
    chk("lit_add_b", bus.b_out, 32'd7);
    drive(7'h63, 3'b001, 1'b0, 5'd6, 32'd3, 32'd3, 32'd8);
    chk("lit_sub_ctrl", {28'd0, bus.alu_ctrl}, 32'h6);
    drive(7'h37, 3'b000, 1'b0, 5'd7, 32'd77, 32'd1, 32'h12345000);
    chk("lit_bne_ctrl", {28'd0, bus.alu_ctrl}, 32'hf);
    chk("lit_bne_inv", {31'd0, bus.br_inv}, 32'd1);
    chk("lit_bne_br", {31'd0, bus.is_branch}, 32'd1);
    drive(7'h33, 3'b001, 1'b0, 5'd9, 32'd11, 32'd12, 32'd13);
    chk("lit_lui_a", bus.a_out, 32'd0);
    chk("lit_lui_b", bus.b_out, 32'h12345000);
    drive(7'h73, 3'b000, 1'b0, 5'd10, 32'd1, 32'd2, 32'd3);
    chk("lit_ill_flag", {31'd0, bus.illegal}, 32'd1);
    chk("lit_ill_a", bus.a_out, 32'd0);
    chk("lit_ill_ctrl", {28'd0, bus.alu_ctrl}, 32'h2);
    chk("lit_ill_rd", {27'd0, bus.rd_out}, 32'd9);
    drive(7'h13, 3'b010, 1'b0, 5'd11, 32'hffff_fff0, 32'd0, 32'd4);
    chk("lit_ecall_ill", {31'd0, bus.illegal}, 32'd1);
    drive(7'h63, 3'b101, 1'b0, 5'd12, 32'd1, 32'd2, 32'd0);
    drive(7'h63, 3'b010, 1'b0, 5'd13, 32'd1, 32'd2, 32'd0);
    drive(7'h23, 3'b010, 1'b0, 5'd14, 32'd100, 32'd5, 32'd16);
    drive(7'h13, 3'b001, 1'b0, 5'd15, 32'd100, 32'd5, 32'd16);
    idle();
    idle();

    // Backpressure: third push is held while full.
    bus.out_ready = 1'b0;
    drive(7'h33, 3'b110, 1'b0, 5'd1, 32'd1, 32'd2, 32'd0);
    drive(7'h33, 3'b111, 1'b0, 5'd2, 32'd3, 32'd4, 32'd0);
    drive(7'h13, 3'b110, 1'b0, 5'd3, 32'd5, 32'd6, 32'd7);
    chk("lit_full_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    #1;
    chk("lit_held_rd", {27'd0, bus.rd_out}, 32'd1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("lit_pop2_rd", {27'd0, bus.rd_out}, 32'd2);
    chk("lit_pop2_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    #1;
    chk("lit_pop3_rd", {27'd0, bus.rd_out}, 32'd3);
    bus.in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("lit_drained", {31'd0, bus.out_valid}, 32'd0);

    // Streaming: one op per cycle, in_ready must never drop.
    for (int i = 0; i < 10; i++) begin
      drive(7'h33, (i % 2 == 0) ? 3'b000 : 3'b010, i[0], 5'(16 + i),
            32'(i * 3), 32'(i + 100), 32'd0);
    end
    idle();
    idle();

    // Asynchronous reset while full.
    bus.out_ready = 1'b0;
    drive(7'h03, 3'b010, 1'b0, 5'd20, 32'd8, 32'd0, 32'd4);
    drive(7'h13, 3'b000, 1'b0, 5'd21, 32'd8, 32'd0, 32'd4);
    idle();
    chk("lit_pre_rst_full", {31'd0, bus.in_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("lit_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("lit_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    drive(7'h13, 3'b111, 1'b0, 5'd22, 32'hf0, 32'd0, 32'h3c);
    idle();
    chk("lit_post_rst_rd", {27'd0, bus.rd_out}, 32'd22);
    chk("lit_post_rst_b", bus.b_out, 32'h3c);
    idle();
    chk("lit_post_rst_alone", {31'd0, bus.out_valid}, 32'd0);
    idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
